// File: rtl/hpu_route_buffer.sv
// hpu_route_buffer
//   Header processing unit for one router input port. Head flits are decoded
//   and routed with dimension-ordered XY routing; the resulting one-hot output
//   select is held for the rest of the packet and stored next to every flit in
//   a DEPTH-entry FIFO that feeds the switch allocator. Packets whose head is
//   unroutable from this port are swallowed up to and including their tail.
//
// Ports
//   clk, preset            clock, asynchronous active-low reset
//   in_valid/in_ready      input channel handshake, in_flit carries the flit
//                          (type in the top two bits: 01 head, 00 body,
//                          10 tail, 11 head+tail)
//   out_valid/out_ready    FIFO head handshake
//   out_flit, out_sel      buffered flit and its one-hot route (0 when empty)
//   out_last               buffered flit ends its packet
//   fifo_count             FIFO occupancy
//   busy                   a packet is in progress (passing or dropping)
//   route_err, proto_err   one-cycle pulses after an accepted offending flit
module hpu_route_buffer #(
  parameter int FLIT_W    = 32,
  parameter int COORD_W   = 3,
  parameter int NUM_PORTS = 5,
  parameter int THIS_PORT = 0,
  parameter int IS_NI     = 0,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     preset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [NUM_PORTS-1:0]     out_sel,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     route_err,
  output logic                     proto_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int ENT_W  = NUM_PORTS + FLIT_W;

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t                 state, nxt_state;
  logic [NUM_PORTS-1:0]   held_sel, nxt_held;
  logic [ENT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;

  logic [1:0]             ftype;
  logic [COORD_W-1:0]     dst_x, dst_y;
  logic [PORT_W-1:0]      route_port;
  logic [NUM_PORTS-1:0]   route_sel;
  logic                   route_bad;
  logic                   accept, push, pop, full;
  logic [NUM_PORTS-1:0]   push_sel;
  logic                   set_rerr, set_perr;
  logic [ENT_W-1:0]       rd_entry;

  assign ftype = in_flit[FLIT_W-1 -: 2];
  assign dst_x = in_flit[2*COORD_W-1:COORD_W];
  assign dst_y = in_flit[COORD_W-1:0];

  // XY routing: resolve X first, then Y, else deliver locally.
  always_comb begin
    route_port = PORT_W'(P_LOCAL);
    if (dst_x > MY_X_C)      route_port = PORT_W'(P_EAST);
    else if (dst_x < MY_X_C) route_port = PORT_W'(P_WEST);
    else if (dst_y > MY_Y_C) route_port = PORT_W'(P_NORTH);
    else if (dst_y < MY_Y_C) route_port = PORT_W'(P_SOUTH);
  end

  assign route_sel = NUM_PORTS'(1) << route_port;

  // A network port may not send a packet back where it came from; a local
  // port may only loop back to its own node when fed by a network interface.
  assign route_bad = ((route_port == PORT_W'(THIS_PORT)) && (THIS_PORT != P_LOCAL)) ||
                     ((IS_NI == 0) && (THIS_PORT == P_LOCAL) &&
                      (route_port == PORT_W'(P_LOCAL)));

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign in_ready = (state == S_DROP) || !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    nxt_state = state;
    nxt_held  = held_sel;
    push      = 1'b0;
    push_sel  = held_sel;
    set_rerr  = 1'b0;
    set_perr  = 1'b0;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (ftype == T_HEAD || ftype == T_HT) begin
            if (route_bad) begin
              set_rerr = 1'b1;
              if (ftype == T_HEAD) nxt_state = S_DROP;
            end else begin
              push     = 1'b1;
              push_sel = route_sel;
              if (ftype == T_HEAD) begin
                nxt_held  = route_sel;
                nxt_state = S_PASS;
              end
            end
          end else begin
            set_perr = 1'b1;
          end
        end
        S_PASS: begin
          if (ftype == T_BODY || ftype == T_TAIL) begin
            push = 1'b1;
            if (ftype == T_TAIL) nxt_state = S_IDLE;
          end else begin
            set_perr = 1'b1;
          end
        end
        S_DROP: begin
          if (ftype == T_TAIL)      nxt_state = S_IDLE;
          else if (ftype != T_BODY) set_perr  = 1'b1;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state     <= S_IDLE;
      held_sel  <= '0;
      busy      <= 1'b0;
      route_err <= 1'b0;
      proto_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= nxt_state;
      held_sel  <= nxt_held;
      busy      <= (nxt_state != S_IDLE);
      route_err <= set_rerr;
      proto_err <= set_perr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_sel, in_flit};
  end

  assign rd_entry   = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_flit   = out_valid ? rd_entry[FLIT_W-1:0] : '0;
  assign out_sel    = out_valid ? rd_entry[ENT_W-1:FLIT_W] : '0;
  assign out_last   = out_valid && rd_entry[FLIT_W-1];
  assign fifo_count = count;

endmodule

// File: tb/tb_hpu_route_buffer.sv
// Randomized bench for hpu_route_buffer. Three instances share one input
// stream: an EAST port, a LOCAL port fed by the network and a LOCAL port fed
// by a network interface, all at router (1,1). Each is compared every cycle
// with a packet-level reference model; one asynchronous reset is applied
// mid-run while the FIFOs are loaded.
module tb_hpu_route_buffer;

  localparam int FLIT_W = 32;
  localparam int NP     = 5;
  localparam int DEPTH  = 4;
  localparam int MYX    = 1;
  localparam int MYY    = 1;
  localparam int NI     = 3;

  logic              clk;
  logic              preset;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              out_ready;

  logic              ready_o [NI];
  logic              valid_o [NI];
  logic [FLIT_W-1:0] flit_o  [NI];
  logic [NP-1:0]     sel_o   [NI];
  logic              last_o  [NI];
  logic [2:0]        cnt_o   [NI];
  logic              busy_o  [NI];
  logic              rerr_o  [NI];
  logic              perr_o  [NI];

  hpu_route_buffer #(.FLIT_W(FLIT_W), .COORD_W(3), .NUM_PORTS(NP), .THIS_PORT(2),
    .IS_NI(0), .MY_X(MYX), .MY_Y(MYY), .DEPTH(DEPTH)) u_east (
    .clk(clk), .preset(preset), .in_valid(in_valid), .in_ready(ready_o[0]),
    .in_flit(in_flit), .out_valid(valid_o[0]), .out_ready(out_ready),
    .out_flit(flit_o[0]), .out_sel(sel_o[0]), .out_last(last_o[0]),
    .fifo_count(cnt_o[0]), .busy(busy_o[0]), .route_err(rerr_o[0]),
    .proto_err(perr_o[0]));

  hpu_route_buffer #(.FLIT_W(FLIT_W), .COORD_W(3), .NUM_PORTS(NP), .THIS_PORT(0),
    .IS_NI(0), .MY_X(MYX), .MY_Y(MYY), .DEPTH(DEPTH)) u_local (
    .clk(clk), .preset(preset), .in_valid(in_valid), .in_ready(ready_o[1]),
    .in_flit(in_flit), .out_valid(valid_o[1]), .out_ready(out_ready),
    .out_flit(flit_o[1]), .out_sel(sel_o[1]), .out_last(last_o[1]),
    .fifo_count(cnt_o[1]), .busy(busy_o[1]), .route_err(rerr_o[1]),
    .proto_err(perr_o[1]));

  hpu_route_buffer #(.FLIT_W(FLIT_W), .COORD_W(3), .NUM_PORTS(NP), .THIS_PORT(0),
    .IS_NI(1), .MY_X(MYX), .MY_Y(MYY), .DEPTH(DEPTH)) u_ni (
    .clk(clk), .preset(preset), .in_valid(in_valid), .in_ready(ready_o[2]),
    .in_flit(in_flit), .out_valid(valid_o[2]), .out_ready(out_ready),
    .out_flit(flit_o[2]), .out_sel(sel_o[2]), .out_last(last_o[2]),
    .fifo_count(cnt_o[2]), .busy(busy_o[2]), .route_err(rerr_o[2]),
    .proto_err(perr_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packet state 0=idle 1=passing 2=dropping, FIFO kept as
  // a shift array whose element 0 is the oldest entry {sel, flit}.
  int                m_st   [NI];
  int                m_cnt  [NI];
  logic [NP+FLIT_W-1:0] m_fifo [NI][DEPTH];
  logic [NP-1:0]     m_held [NI];
  logic              m_rerr [NI];
  logic              m_perr [NI];

  function automatic int tp_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int ni_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  // Port numbers: 0 local, 1 north, 2 east, 3 south, 4 west.
  function automatic int route_of(input int dx, input int dy);
    if (dx > MYX) return 2;
    if (dx < MYX) return 4;
    if (dy > MYY) return 1;
    if (dy < MYY) return 3;
    return 0;
  endfunction

  function automatic bit legal(input int port, input int tp, input int ni);
    if (port == tp && tp != 0) return 1'b0;
    if (ni == 0 && tp == 0 && port == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_held[i] = '0;
      m_rerr[i] = 1'b0; m_perr[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit rdy, acc, ok, do_push;
    int ty, port;
    logic [NP-1:0] sel, psel;
    rdy = (m_st[i] == 2) || (m_cnt[i] < DEPTH);
    acc = in_valid && rdy;
    ty   = int'(in_flit[31:30]);
    port = route_of(int'(in_flit[5:3]), int'(in_flit[2:0]));
    sel  = NP'(1 << port);
    ok   = legal(port, tp_of(i), ni_of(i));
    m_rerr[i] = 1'b0; m_perr[i] = 1'b0;
    do_push = 1'b0; psel = m_held[i];
    if (acc) begin
      if (m_st[i] == 0) begin
        if (ty == 1 || ty == 3) begin
          if (!ok) begin
            m_rerr[i] = 1'b1;
            if (ty == 1) m_st[i] = 2;
          end else begin
            do_push = 1'b1; psel = sel;
            if (ty == 1) begin m_held[i] = sel; m_st[i] = 1; end
          end
        end else m_perr[i] = 1'b1;
      end else if (m_st[i] == 1) begin
        if (ty == 0 || ty == 2) begin
          do_push = 1'b1;
          if (ty == 2) m_st[i] = 0;
        end else m_perr[i] = 1'b1;
      end else begin
        if (ty == 2) m_st[i] = 0;
        else if (ty != 0) m_perr[i] = 1'b1;
      end
    end
    if (m_cnt[i] > 0 && out_ready) begin
      for (int k = 0; k < DEPTH-1; k++) m_fifo[i][k] = m_fifo[i][k+1];
      m_cnt[i]--;
    end
    if (do_push) begin
      m_fifo[i][m_cnt[i]] = {psel, in_flit};
      m_cnt[i]++;
    end
  endtask

  task automatic check_dut(input int i);
    logic [NP+FLIT_W-1:0] e;
    bit ev;
    ev = (m_cnt[i] > 0);
    e  = ev ? m_fifo[i][0] : '0;
    chk($sformatf("u%0d.in_ready", i), 64'(ready_o[i]), 64'((m_st[i] == 2) || (m_cnt[i] < DEPTH)));
    chk($sformatf("u%0d.out_valid", i), 64'(valid_o[i]), 64'(ev));
    chk($sformatf("u%0d.fifo_count", i), 64'(cnt_o[i]), 64'(m_cnt[i]));
    chk($sformatf("u%0d.busy", i), 64'(busy_o[i]), 64'(m_st[i] != 0));
    chk($sformatf("u%0d.route_err", i), 64'(rerr_o[i]), 64'(m_rerr[i]));
    chk($sformatf("u%0d.proto_err", i), 64'(perr_o[i]), 64'(m_perr[i]));
    chk($sformatf("u%0d.out_flit", i), 64'(flit_o[i]), 64'(e[FLIT_W-1:0]));
    chk($sformatf("u%0d.out_sel", i), 64'(sel_o[i]), 64'(e[NP+FLIT_W-1:FLIT_W]));
    chk($sformatf("u%0d.out_last", i), 64'(last_o[i]), 64'(ev && e[FLIT_W-1]));
  endtask

  bit gen_pkt = 1'b0;

  task automatic drive_random(input int c);
    int r, ph;
    logic [1:0] ty;
    logic [2:0] x, y;
    in_valid = ($urandom_range(0, 3) != 0);
    r = $urandom_range(0, 9);
    if (gen_pkt) ty = (r < 5) ? 2'b00 : (r < 9) ? 2'b10 : 2'b01;
    else         ty = (r < 5) ? 2'b01 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b10;
    x = 3'($urandom_range(0, 3));
    y = 3'($urandom_range(0, 3));
    in_flit = {ty, 24'($urandom), x, y};
    if (in_valid) begin
      if (ty == 2'b01) gen_pkt = 1'b1;
      else if (ty[1]) gen_pkt = 1'b0;
    end
    ph = (c / 150) % 3;
    if (c >= 980 && c < 1000) out_ready = 1'b0;
    else if (ph == 0)         out_ready = ($urandom_range(0, 9) != 0);
    else if (ph == 1)         out_ready = ($urandom_range(0, 9) == 0);
    else                      out_ready = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    preset = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) check_dut(i);
    preset = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) check_dut(i);
      if (c == 1000) begin
        in_valid = 1'b0;
        #2 preset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("u%0d.rst_valid", i), 64'(valid_o[i]), 64'(0));
          chk($sformatf("u%0d.rst_count", i), 64'(cnt_o[i]), 64'(0));
          chk($sformatf("u%0d.rst_busy", i), 64'(busy_o[i]), 64'(0));
          chk($sformatf("u%0d.rst_sel", i), 64'(sel_o[i]), 64'(0));
          chk($sformatf("u%0d.rst_flit", i), 64'(flit_o[i]), 64'(0));
        end
        @(posedge clk);
        #1 preset = 1'b1;
        gen_pkt = 1'b0;
      end else begin
        drive_random(c);
        for (int i = 0; i < NI; i++) model_step(i);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_dut(i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
